// File: rtl/alu_arb_pkg.sv
// Shared types and sizing helpers for the round-robin ALU arbiter.
package alu_arb_pkg;

  // Sequencer states: accept a request, issue it, wait for the result,
  // then return the response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Owner index width for the default requester count.
  localparam int OWNER_W = $clog2(4);

  // Owner index width for an arbitrary requester count (at least 1 bit).
  function automatic int owner_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_picker.sv
// Combinational round-robin priority encoder. The search starts just after
// ptr and wraps, so the most recently granted requester has lowest priority.
module rr_picker
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = owner_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  int   idx;
  logic found;

  // Walk ptr+1 .. ptr+NUM_REQ (mod NUM_REQ) and take the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = |req;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters. One operation is in
// flight at a time: accept (IDLE) -> drive ALU for one cycle (ISSUE) ->
// wait for result or timeout (WAIT) -> one-cycle response pulse (RESP).
//
// Handshake: a request transfers in the cycle where i_req_valid[k] and
// o_req_ready[k] are both high. Ready is raised only in IDLE, only for the
// round-robin winner, and is combinational on the valid vector so a
// requester may withdraw by dropping valid before it sees ready. Responses
// have no backpressure: the owner must take o_rsp_* in the pulse cycle.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*INST_WIDTH-1:0] i_req_inst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_b,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_alu_valid,
  output logic [INST_WIDTH-1:0]         o_alu_inst,
  output logic [DATA_WIDTH-1:0]         o_alu_a,
  output logic [DATA_WIDTH-1:0]         o_alu_b,
  input  logic [DATA_WIDTH-1:0]         i_alu_data,
  input  logic                          i_alu_overflow,
  input  logic                          i_alu_valid,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_overflow,
  output logic                          o_rsp_err,
  output logic                          o_busy
);

  localparam int IDX_W = owner_idx_w(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e          state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    owner;
  logic [CNT_W-1:0]    cnt;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (i_req_valid),
    .ptr       (ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  // Ready only in IDLE; also held low while reset is asserted so every
  // output reads 0 during reset.
  always_comb begin
    o_req_ready = '0;
    if (i_rst_n && state == IDLE) o_req_ready = pick_grant;
  end

  // Busy whenever an operation is in flight.
  always_comb begin
    o_busy = (state != IDLE);
  end

  // Sequencer FSM with registered ALU drive and response outputs. The ALU
  // drive registers double as the operand latch since issue lasts one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      ptr            <= IDX_W'(NUM_REQ - 1);
      owner          <= '0;
      cnt            <= '0;
      o_alu_valid    <= 1'b0;
      o_alu_inst     <= '0;
      o_alu_a        <= '0;
      o_alu_b        <= '0;
      o_rsp_valid    <= '0;
      o_rsp_data     <= '0;
      o_rsp_overflow <= 1'b0;
      o_rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner       <= pick_idx;
            ptr         <= pick_idx;
            o_alu_valid <= 1'b1;
            o_alu_inst  <= i_req_inst[pick_idx*INST_WIDTH +: INST_WIDTH];
            o_alu_a     <= i_req_a[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            o_alu_b     <= i_req_b[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          o_alu_valid <= 1'b0;
          o_alu_inst  <= '0;
          o_alu_a     <= '0;
          o_alu_b     <= '0;
          cnt         <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          if (i_alu_valid) begin
            o_rsp_valid    <= ONE_HOT0 << owner;
            o_rsp_data     <= i_alu_data;
            o_rsp_overflow <= i_alu_overflow;
            o_rsp_err      <= 1'b0;
            state          <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            o_rsp_valid    <= ONE_HOT0 << owner;
            o_rsp_data     <= '0;
            o_rsp_overflow <= 1'b0;
            o_rsp_err      <= 1'b1;
            state          <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          o_rsp_valid    <= '0;
          o_rsp_data     <= '0;
          o_rsp_overflow <= 1'b0;
          o_rsp_err      <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
